pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits below both caches, above the memory model.
- The pipeline stall unit keys off the per-side `*_resp` pulses this block returns; the stall behaviour itself is unchanged.
- Serves one full-line transaction at a time and prevents I-fetch starvation under D-traffic bursts.

Parameters:
- ADDR_W, 16, physical address width
- LINE_W, 256, cache line width in bits
- MAX_D_STREAK, 4, consecutive D grants allowed while an I request waits (1..7)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_pmem_read  in  1  I-cache line fill request
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_rdata  out  LINE_W  fill data to I-cache
- i_pmem_resp  out  1  I transaction complete, 1-cycle pulse
- d_pmem_read  in  1  D-cache line fill request
- d_pmem_write  in  1  D-cache writeback request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  writeback data
- d_pmem_rdata  out  LINE_W  fill data to D-cache
- d_pmem_resp  out  1  D transaction complete, 1-cycle pulse
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete

Behaviour:
- Reset (clk edge with rst_n=0):
  - State = IDLE, streak = 0.
  - All outputs low: pmem_read, pmem_write, both `*_resp`. pmem_address, pmem_wdata and both `*_rdata` = 0.
  - Reset mid-transaction abandons it; memory is reset alongside.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE arbitration:
  - Evaluated each cycle; the result is registered.
  - Winner's op, address and wdata are latched into hold registers at the grant edge.
- Priority:
  - D wins when both request, unless streak == MAX_D_STREAK; then I wins.
  - Lone requester always wins.
- Streak counter:
  - Increments on a D grant while i_pmem_read=1.
  - Clears on any I grant, or on a D grant with i_pmem_read=0.
  - Saturates at MAX_D_STREAK.
- Op decode: d_pmem_read and d_pmem_write both high is illegal; treated as a write.
- SERVE_x:
  - pmem_read/pmem_write driven from the latched op; pmem_address and pmem_wdata from the hold registers.
  - Requester inputs are ignored after the grant.
- Grant latency: one cycle. Request seen in IDLE at edge N means the command is driven during cycle N+1.
- On pmem_resp=1 in SERVE_x:
  - x_pmem_resp=1 combinationally in the same cycle.
  - x_pmem_rdata = pmem_rdata combinationally.
  - Next state DONE; pmem command drops.
- `*_rdata` outside a resp cycle: the non-granted side's rdata is 0, and the granted side's rdata is 0 except during its resp cycle.
- DONE: one idle cycle with no command and no resp, so the requester can deassert; then IDLE. Back-to-back transactions therefore cost 2 dead cycles.
- Requester withdraws before resp: command continues with the latched values until pmem_resp; the resp pulse to that requester is still issued.
- pmem_resp outside SERVE_x: ignored.
- Never more than one of pmem_read or pmem_write high. Never both `*_resp` high in the same cycle.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants, perf_d_grants and perf_conflicts, each 32-bit.
  - perf_i_grants and perf_d_grants increment once per grant.
  - perf_conflicts increments once per arbitration where both sides requested.
  - All three saturate at 32'hFFFF_FFFF and clear on rst_n=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Lone I read at 16'h0040, memory resp 3 cycles after command:
  - pmem_read high cycles N+1..N+3 with pmem_address=16'h0040.
  - i_pmem_resp pulse at cycle N+3 carrying pmem_rdata; DONE at N+4; IDLE at N+5.
- I read (16'h0100) and D write (16'h8000, wdata all 8'hA5) raised in the same cycle:
  - D served first with pmem_write=1 and wdata=8'hA5 pattern.
  - Then I served; d_pmem_resp precedes i_pmem_resp.
- I held high while D issues 6 back-to-back reads, MAX_D_STREAK=4:
  - Grant order D,D,D,D,I,D,D.
  - Streak returns to 0 after the I grant.
- D asserts read and write together at 16'h1230:
  - pmem_write=1, pmem_read=0, pmem_address=16'h1230.
- D withdraws request one cycle after grant, address input changed to 16'hFFFF:
  - pmem_address stays at the latched value until pmem_resp; d_pmem_resp still pulses once.
- rst_n=0 mid-SERVE_I:
  - Next edge: all outputs 0 and state IDLE.
  - A later pmem_resp produces no `*_resp`.
  - With ARB_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the I-cache fill path
// and the D-cache fill/writeback path. One full-line transaction at a time;
// D has priority but can win at most MAX_D_STREAK times in a row while I waits.
// Optional macro ARB_PERF_EN adds saturating grant/conflict counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate every cycle, latch winner's command on the grant edge
// SERVE_I | drive latched I command until pmem_resp
// SERVE_D | drive latched D command until pmem_resp
// DONE    | one dead cycle so the requester can drop its request
module pmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

    state_t              state;
    state_t              state_next;
    logic [2:0]          streak;
    logic                hold_write;
    logic [ADDR_W-1:0]   hold_addr;
    logic [LINE_W-1:0]   hold_wdata;
    logic                i_req;
    logic                d_req;
    logic                grant_i;
    logic                grant_d;
    logic                serving;

    // Request decode; D read+write together counts as a single D request.
    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // D wins ties unless it has used up its streak while I was waiting.
    assign grant_i = (state == IDLE) && i_req && (!d_req || (streak == STREAK_MAX));
    assign grant_d = (state == IDLE) && d_req && !grant_i;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next = SERVE_I;
                end else if (grant_d) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's command and track consecutive D wins over a waiting I.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            streak     <= 3'd0;
        end else if (grant_i) begin
            hold_write <= 1'b0;
            hold_addr  <= i_pmem_address;
            hold_wdata <= '0;
            streak     <= 3'd0;
        end else if (grant_d) begin
            hold_write <= d_pmem_write;
            hold_addr  <= d_pmem_address;
            hold_wdata <= d_pmem_wdata;
            if (!i_req) begin
                streak <= 3'd0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 3'd1;
            end
        end
    end

    // Memory command and per-side response outputs.
    always_comb begin
        serving      = (state == SERVE_I) || (state == SERVE_D);
        pmem_read    = serving && !hold_write;
        pmem_write   = serving && hold_write;
        pmem_address = serving ? hold_addr : '0;
        pmem_wdata   = serving ? hold_wdata : '0;
        i_pmem_resp  = (state == SERVE_I) && pmem_resp;
        d_pmem_resp  = (state == SERVE_D) && pmem_resp;
        i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
        d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;
    end

`ifdef ARB_PERF_EN
    // Saturating grant and conflict counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (grant_i && (perf_i_grants != 32'hFFFF_FFFF)) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (grant_d && (perf_d_grants != 32'hFFFF_FFFF)) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if ((state == IDLE) && i_req && d_req && (perf_conflicts != 32'hFFFF_FFFF)) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_pmem_arbiter;
    localparam int AW = 16;
    localparam int LW = 256;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
`ifdef ARB_PERF_EN
    logic [31:0]   perf_i_grants;
    logic [31:0]   perf_d_grants;
    logic [31:0]   perf_conflicts;
`endif

    int checks = 0;
    int failures = 0;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef ARB_PERF_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Move to the drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the sample point of the current cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic quiet();
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 0;
        i_pmem_read = 1; d_pmem_write = 1; pmem_resp = 1; pmem_rdata = {8{32'hDEADBEEF}};
        cyc(); cyc();
        smp();
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL reset_cmd got=%b exp=00", {pmem_read, pmem_write}); end
        checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        checks++; if (pmem_address !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", pmem_address); end
        checks++; if (pmem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata); end
        checks++; if ((i_pmem_rdata | d_pmem_rdata) !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", i_pmem_rdata | d_pmem_rdata); end
        cyc();
        quiet();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_lone_i();
        logic [LW-1:0] rd;
        rd = {8{$urandom}};
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k == 3) begin pmem_resp = 1; pmem_rdata = rd; end
            smp();
            checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0040) begin failures++; $display("FAIL lone_cmd_n%0d got rd=%b addr=%h exp rd=1 addr=0040", k, pmem_read, pmem_address); end
        end
        checks++; if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== rd) begin failures++; $display("FAIL lone_resp got resp=%b data=%h exp resp=1 data=%h", i_pmem_resp, i_pmem_rdata, rd); end
        checks++; if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin failures++; $display("FAIL lone_dside got resp=%b data=%h exp 0", d_pmem_resp, d_pmem_rdata); end
        cyc();
        i_pmem_read = 0; pmem_resp = 1;
        smp();
        checks++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin failures++; $display("FAIL lone_done got=%b exp=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
        checks++; if (i_pmem_rdata !== '0) begin failures++; $display("FAIL lone_done_rdata got=%h exp=0", i_pmem_rdata); end
        cyc();
        pmem_resp = 0;
        smp();
        checks++; if ({pmem_read, pmem_write, i_pmem_resp} !== 3'b000) begin failures++; $display("FAIL lone_idle got=%b exp=000", {pmem_read, pmem_write, i_pmem_resp}); end
        quiet();
        cyc();
    endtask

    task automatic test_conflict();
        logic [LW-1:0] pat;
        pat = {32{8'hA5}};
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_write = 1; d_pmem_address = 16'h8000; d_pmem_wdata = pat;
        cyc(); smp();
        checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000 || pmem_wdata !== pat) begin failures++; $display("FAIL conf_dfirst got wr=%b rd=%b addr=%h wdata=%h", pmem_write, pmem_read, pmem_address, pmem_wdata); end
        cyc(); pmem_resp = 1; smp();
        checks++; if ({d_pmem_resp, i_pmem_resp} !== 2'b10) begin failures++; $display("FAIL conf_dresp got d,i=%b exp=10", {d_pmem_resp, i_pmem_resp}); end
        cyc(); pmem_resp = 0; d_pmem_write = 0; d_pmem_wdata = '0; smp();
        cyc(); smp();
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL conf_dead got=%b exp=00", {pmem_read, pmem_write}); end
        cyc(); smp();
        checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0100 || pmem_wdata !== '0) begin failures++; $display("FAIL conf_ithen got rd=%b addr=%h", pmem_read, pmem_address); end
        cyc(); pmem_resp = 1; smp();
        checks++; if ({d_pmem_resp, i_pmem_resp} !== 2'b01) begin failures++; $display("FAIL conf_iresp got d,i=%b exp=01", {d_pmem_resp, i_pmem_resp}); end
        cyc(); quiet(); cyc();
    endtask

    task automatic test_streak();
        int seq[7];
        int exp_seq[7];
        int n_ev;
        int nd;
        exp_seq = '{1, 1, 1, 1, 0, 1, 1};
        for (int k = 0; k < 7; k++) seq[k] = -1;
        n_ev = 0; nd = 0;
        i_pmem_read = 1; i_pmem_address = 16'h0200;
        d_pmem_read = 1; d_pmem_address = 16'h3000;
        pmem_resp = 1;
        for (int c = 0; c < 100 && n_ev < 7; c++) begin
            cyc();
            if (nd >= 6) d_pmem_read = 0;
            smp();
            if (i_pmem_resp) begin seq[n_ev] = 0; n_ev++; end
            if (d_pmem_resp && n_ev < 7) begin seq[n_ev] = 1; n_ev++; nd++; end
        end
        checks++; if (n_ev != 7) begin failures++; $display("FAIL streak_timeout got events=%0d exp=7", n_ev); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (seq[k] != exp_seq[k]) begin failures++; $display("FAIL streak_order_%0d got=%0d exp=%0d (1=D 0=I)", k, seq[k], exp_seq[k]); end
        end
        cyc(); quiet(); cyc(); cyc();
    endtask

    task automatic test_rw_both();
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h1230; d_pmem_wdata = {8{32'h1234_5678}};
        cyc(); smp();
        checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h1230) begin failures++; $display("FAIL rw_both got wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=1230", pmem_write, pmem_read, pmem_address); end
        cyc(); pmem_resp = 1; smp();
        checks++; if (d_pmem_resp !== 1'b1) begin failures++; $display("FAIL rw_both_resp got=%b exp=1", d_pmem_resp); end
        cyc(); quiet(); cyc();
    endtask

    task automatic test_withdraw();
        int pulses;
        pulses = 0;
        d_pmem_read = 1; d_pmem_address = 16'h4440;
        cyc();
        d_pmem_read = 0; d_pmem_address = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) pmem_resp = 1;
            smp();
            checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h4440) begin failures++; $display("FAIL withdraw_hold_%0d got rd=%b addr=%h exp rd=1 addr=4440", k, pmem_read, pmem_address); end
            pulses += int'(d_pmem_resp);
            cyc();
        end
        pmem_resp = 0;
        for (int k = 0; k < 3; k++) begin
            smp();
            pulses += int'(d_pmem_resp);
            checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL withdraw_after_%0d got=%b exp=00", k, {pmem_read, pmem_write}); end
            cyc();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL withdraw_pulses got=%0d exp=1", pulses); end
        quiet();
    endtask

    task automatic test_reset_mid();
        i_pmem_read = 1; i_pmem_address = 16'h0500;
        cyc(); smp();
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rstmid_serve got=%b exp=1", pmem_read); end
        cyc();
        rst_n = 0; i_pmem_read = 0;
        cyc(); smp();
        checks++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || pmem_address !== '0) begin failures++; $display("FAIL rstmid_out got=%b addr=%h exp=0000 addr=0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address); end
`ifdef ARB_PERF_EN
        checks++; if ({perf_i_grants, perf_d_grants, perf_conflicts} !== 96'd0) begin failures++; $display("FAIL rstmid_perf got i=%0d d=%0d c=%0d exp 0", perf_i_grants, perf_d_grants, perf_conflicts); end
`endif
        cyc();
        rst_n = 1; pmem_resp = 1; pmem_rdata = {8{32'hCAFE_F00D}};
        for (int k = 0; k < 3; k++) begin
            smp();
            checks++; if ({i_pmem_resp, d_pmem_resp, pmem_read} !== 3'b000 || i_pmem_rdata !== '0) begin failures++; $display("FAIL rstmid_stray_%0d got=%b exp=000", k, {i_pmem_resp, d_pmem_resp, pmem_read}); end
            cyc();
        end
        quiet();
    endtask

    task automatic test_random();
        int phase;          // 0 waiting for grant, 1 command out, 2 dead cycle
        bit srv_i;
        bit srv_wr;
        logic [AW-1:0] srv_addr;
        logic [LW-1:0] srv_wdata;
        int lat;
        int streak;
        bit i_pend, d_pend;
        logic [AW-1:0] i_addr_r, d_addr_r;
        logic [LW-1:0] d_wdata_r;
        bit d_rd_r, d_wr_r;
        int i_issued, d_issued, i_seen, d_seen;
        int n_igr, n_dgr, n_conf;
        int rd_ok;
        bit ireq, dreq;
        logic [LW-1:0] exp_i_rd, exp_d_rd;
        phase = 0; streak = 0; i_pend = 0; d_pend = 0;
        i_issued = 0; d_issued = 0; i_seen = 0; d_seen = 0;
        n_igr = 0; n_dgr = 0; n_conf = 0; lat = 0;
        srv_i = 0; srv_wr = 0; srv_addr = '0; srv_wdata = '0;
        i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0; d_rd_r = 0; d_wr_r = 0;
        rd_ok = 1;
        quiet();
        rst_n = 0; cyc(); rst_n = 1;
        for (int n = 0; n < 900; n++) begin
            if (!i_pend && n < 700 && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr_r = AW'($urandom); i_issued++;
            end
            if (!d_pend && n < 700 && $urandom_range(0, 1) == 0) begin
                d_pend = 1; d_addr_r = AW'($urandom); d_wdata_r = {8{$urandom}};
                case ($urandom_range(0, 2))
                    0: begin d_rd_r = 1; d_wr_r = 0; end
                    1: begin d_rd_r = 0; d_wr_r = 1; end
                    default: begin d_rd_r = 1; d_wr_r = 1; end
                endcase
                d_issued++;
            end
            if (phase == 1 && srv_i) begin
                i_pmem_read = 1'($urandom_range(0, 1)); i_pmem_address = AW'($urandom);
            end else begin
                i_pmem_read = i_pend; i_pmem_address = i_addr_r;
            end
            if (phase == 1 && !srv_i) begin
                d_pmem_read = 1'($urandom_range(0, 1)); d_pmem_write = 1'($urandom_range(0, 1));
                d_pmem_address = AW'($urandom); d_pmem_wdata = {8{$urandom}};
            end else begin
                d_pmem_read = d_pend && d_rd_r; d_pmem_write = d_pend && d_wr_r;
                d_pmem_address = d_addr_r; d_pmem_wdata = d_wdata_r;
            end
            pmem_resp = (phase == 1) ? (lat == 0) : ($urandom_range(0, 3) == 0);
            pmem_rdata = {8{$urandom}};
            smp();
            exp_i_rd = (phase == 1 && srv_i && pmem_resp) ? pmem_rdata : '0;
            exp_d_rd = (phase == 1 && !srv_i && pmem_resp) ? pmem_rdata : '0;
            checks++;
            if (pmem_read !== (phase == 1 && !srv_wr) || pmem_write !== (phase == 1 && srv_wr)) begin
                failures++; $display("FAIL rnd_cmd n=%0d got rd=%b wr=%b exp rd=%b wr=%b", n, pmem_read, pmem_write, phase == 1 && !srv_wr, phase == 1 && srv_wr);
            end
            checks++;
            if (pmem_address !== ((phase == 1) ? srv_addr : '0) || pmem_wdata !== ((phase == 1) ? srv_wdata : '0)) begin
                failures++; $display("FAIL rnd_addr n=%0d got addr=%h exp=%h", n, pmem_address, (phase == 1) ? srv_addr : '0);
            end
            checks++;
            if (i_pmem_resp !== (phase == 1 && srv_i && pmem_resp) || d_pmem_resp !== (phase == 1 && !srv_i && pmem_resp)) begin
                failures++; $display("FAIL rnd_resp n=%0d got i=%b d=%b", n, i_pmem_resp, d_pmem_resp);
            end
            if (i_pmem_rdata !== exp_i_rd || d_pmem_rdata !== exp_d_rd) rd_ok = 0;
            i_seen += int'(i_pmem_resp);
            d_seen += int'(d_pmem_resp);
            if (phase == 1) begin
                if (pmem_resp) begin
                    phase = 2;
                    if (srv_i) i_pend = 0; else d_pend = 0;
                end else begin
                    lat--;
                end
            end else if (phase == 2) begin
                phase = 0;
            end else begin
                ireq = i_pmem_read;
                dreq = d_pmem_read || d_pmem_write;
                if (ireq || dreq) begin
                    if (ireq && dreq) n_conf++;
                    srv_i = ireq && (!dreq || streak == MAXS);
                    srv_wr = !srv_i && d_pmem_write;
                    srv_addr = srv_i ? i_pmem_address : d_pmem_address;
                    srv_wdata = srv_i ? '0 : d_pmem_wdata;
                    if (srv_i) begin streak = 0; n_igr++; end
                    else begin streak = ireq ? ((streak < MAXS) ? streak + 1 : MAXS) : 0; n_dgr++; end
                    lat = $urandom_range(0, 3);
                    phase = 1;
                end
            end
            cyc();
        end
        checks++; if (rd_ok != 1) begin failures++; $display("FAIL rnd_rdata got mismatching rdata in run"); end
        checks++; if (i_seen != i_issued || d_seen != d_issued) begin failures++; $display("FAIL rnd_drain got i=%0d d=%0d exp i=%0d d=%0d", i_seen, d_seen, i_issued, d_issued); end
`ifdef ARB_PERF_EN
        checks++; if (perf_i_grants !== 32'(n_igr) || perf_d_grants !== 32'(n_dgr) || perf_conflicts !== 32'(n_conf)) begin
            failures++; $display("FAIL rnd_perf got i=%0d d=%0d c=%0d exp i=%0d d=%0d c=%0d", perf_i_grants, perf_d_grants, perf_conflicts, n_igr, n_dgr, n_conf);
        end
`endif
        quiet();
    endtask

    initial begin
        rst_n = 0;
        quiet();
        test_reset();
        test_lone_i();
        test_conflict();
        test_streak();
        test_rw_both();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
